// File: rtl/mips_bus_bridge.sv
// mips_bus_bridge: MIPS CPU to single-cycle memory bridge with address checking and sticky bus error.
// Define BUS_STALL_INJECT_EN to add LFSR-driven random wait states before each legal access.
module mips_bus_bridge #(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [31:0] mem_address,
  output logic        mem_wr_en,
  output logic        mem_read_en,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        bus_error,
  output logic [15:0] access_count
);
`ifdef BUS_STALL_INJECT_EN
  typedef enum logic [2:0] {IDLE, STALL, RD, RD_CAP, WR, ACK} state_t;
  logic [7:0] lfsr_q;
  logic [1:0] stall_q;
  logic       is_rd_q;
`else
  typedef enum logic [2:0] {IDLE, RD, RD_CAP, WR, ACK} state_t;
`endif
  state_t      state_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic        rd_en_q, wr_en_q, err_q;
  logic [15:0] cnt_q, cnt_d;
  logic        legal;
  // Legal windows: low 1 KB of RAM and the 3 KB boot ROM at 0xBFC00000, word aligned only.
  assign legal = address[1:0] == 2'b00 &&
                 (address < 32'h0000_0400 || (address >= 32'hBFC0_0000 && address < 32'hBFC0_0C00));
  assign cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef BUS_STALL_INJECT_EN
      lfsr_q  <= LFSR_SEED;
      stall_q <= '0;
      is_rd_q <= 1'b0;
`endif
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE:
          if (read | write) begin
            if ((read & write) | !legal) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              cnt_q   <= cnt_d;
              state_q <= ACK;
            end else begin
              addr_q  <= address;
              be_q    <= byteenable;
              wdata_q <= writedata;
`ifdef BUS_STALL_INJECT_EN
              lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
              is_rd_q <= read;
              stall_q <= lfsr_q[1:0];
              if (lfsr_q[1:0] == 2'd0) begin
                state_q <= read ? RD : WR;
                rd_en_q <= read;
                wr_en_q <= write;
              end else
                state_q <= STALL;
`else
              state_q <= read ? RD : WR;
              rd_en_q <= read;
              wr_en_q <= write;
`endif
            end
          end
`ifdef BUS_STALL_INJECT_EN
        STALL: begin
          stall_q <= stall_q - 2'd1;
          if (stall_q == 2'd1) begin
            state_q <= is_rd_q ? RD : WR;
            rd_en_q <= is_rd_q;
            wr_en_q <= !is_rd_q;
          end
        end
`endif
        RD: state_q <= RD_CAP;
        RD_CAP: begin
          rdata_q <= mem_data_out;
          cnt_q   <= cnt_d;
          state_q <= ACK;
        end
        WR: begin
          cnt_q   <= cnt_d;
          state_q <= ACK;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign waitrequest  = (read | write) && state_q != ACK;
  assign readdata     = rdata_q;
  assign mem_address  = addr_q;
  assign mem_wr_en    = wr_en_q;
  assign mem_read_en  = rd_en_q;
  assign mem_byte_en  = be_q;
  assign mem_data_in  = wdata_q;
  assign bus_error    = err_q;
  assign access_count = cnt_q;
endmodule

// File: doc/mips_bus_bridge.md
MIPS_BUS_BRIDGE -- requirements
Module: mips_bus_bridge

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 8'hA5, the nonzero reset value of the stall LFSR.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports address, read, write, byteenable and writedata, all CPU-side inputs, widths 32, 1, 1, 4 and 32: word address, read request, write request, byte lanes, store data.
REQ-005 SHALL have port readdata  output  32  load data, valid while waitrequest=0 on a read.
REQ-006 SHALL have port waitrequest  output  1  high = CPU must hold its request stable.
REQ-007 SHALL have ports mem_address, mem_wr_en, mem_read_en, mem_byte_en and mem_data_in, all memory-side outputs, widths 32, 1, 1, 4 and 32.
REQ-008 SHALL have port mem_data_out  input  32  memory read data, registered one edge after mem_read_en.
REQ-009 SHALL have port bus_error  output  1  sticky fault flag.
REQ-010 SHALL have port access_count  output  16  completed-access counter.

Function
REQ-011 SHALL implement states IDLE, STALL, RD, RD_CAP, WR, ACK.
REQ-012 In IDLE with read^write=1 and a legal request, SHALL latch address, byteenable and writedata, then go to STALL when stalling is compiled in, else to RD or WR.
REQ-013 A request SHALL be legal only when address[1:0]=0 and address<32'h00000400 or 32'hBFC00000<=address<32'hBFC00C00.
REQ-014 An illegal request, or read&write=1, SHALL set bus_error, make no memory access, and go to ACK with readdata=0.
REQ-015 RD SHALL drive mem_read_en=1 for exactly one cycle with mem_address=latched address, then go to RD_CAP.
REQ-016 RD_CAP SHALL register mem_data_out into readdata, then go to ACK.
REQ-017 WR SHALL drive mem_wr_en=1 for one cycle with latched address, byte_en and data, then go to ACK.
REQ-018 mem_read_en and mem_wr_en SHALL never be high together, and SHALL be low in every state other than RD and WR respectively.
REQ-019 waitrequest SHALL equal (read|write) and (state!=ACK).
REQ-020 ACK SHALL last one cycle and always return to IDLE; a request present in that following IDLE cycle SHALL start a new access.
REQ-021 Unstalled latency, counted from the first request cycle (cycle 0): read waitrequest=0 at cycle 3, write waitrequest=0 at cycle 2, illegal request waitrequest=0 at cycle 1.
REQ-022 readdata SHALL hold its value until the next RD_CAP or illegal request.
REQ-023 access_count SHALL increment on each ACK (legal or illegal) and saturate at 16'hFFFF.
REQ-024 mem_address SHALL always be the latched, untranslated CPU address, because the memory performs the translation itself.

Reset
REQ-025 While rst_n=0, state SHALL be IDLE and every output SHALL be 0, except waitrequest, which follows REQ-019.
REQ-026 Reset in RD or WR SHALL deassert the memory strobes immediately, and the aborted access SHALL not complete or count.
REQ-027 After reset the LFSR SHALL equal LFSR_SEED.

Configuration
REQ-028 Macro BUS_STALL_INJECT_EN, when defined, SHALL compile in an 8-bit Fibonacci LFSR (taps 8,6,5,4).
REQ-029 With BUS_STALL_INJECT_EN defined, the LFSR SHALL advance once per accepted request, and STALL SHALL last LFSR[1:0] cycles (0 cycles means a direct pass to RD/WR) before the access proceeds.
REQ-030 With BUS_STALL_INJECT_EN undefined, there SHALL be no STALL state and no LFSR, and the latency SHALL be exactly REQ-021.

Verification
REQ-031 Write 32'hBFC00010, byteenable 4'hF, data 32'hDEADBEEF -> mem_wr_en exactly one cycle, waitrequest=0 at cycle 2, access_count=1.
REQ-032 Read 32'hBFC00010 after REQ-031 -> mem_read_en exactly one cycle, readdata=32'hDEADBEEF with waitrequest=0 at cycle 3.
REQ-033 Read 32'h00000002 -> no memory strobe, bus_error=1, readdata=0 at cycle 1; bus_error stays 1 across later legal accesses.
REQ-034 read=1 and write=1 to 32'h00000010 -> bus_error=1, no strobe, ACK at cycle 1.
REQ-035 rst_n pulsed low during WR -> mem_wr_en drops asynchronously, state IDLE, access_count unchanged, memory word unchanged.
REQ-036 With BUS_STALL_INJECT_EN defined, 100 back-to-back reads -> each waitrequest low period is 1 cycle, read latency is between 3 and 6 cycles, and readdata matches the model every time.
